// File: rtl/dma_ahb_write_engine_if.sv
// AHB-Lite bus bundle between the DMA destination write engine (master)
// and the downstream AHB slave / interconnect.
interface dma_ahb_write_engine_if;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;

  modport master (
    input  HREADY,
    input  HRESP,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HSIZE,
    output HBURST,
    output HWDATA
  );

  modport slave (
    output HREADY,
    output HRESP,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HSIZE,
    input  HBURST,
    input  HWDATA
  );
endinterface

// File: rtl/dma_ahb_write_engine.sv
// Destination-side AHB-Lite write master of a DMA channel. Pops words from
// the channel FIFO's show-ahead port and issues them as pipelined 32-bit
// write transfers to an incrementing or fixed address, reporting busy,
// done and sticky error status to the channel controller.
module dma_ahb_write_engine (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            dst_addr,
  input  logic [15:0]            beat_count,
  input  logic                   dst_inc,
  input  logic [31:0]            fifo_rdata,
  input  logic                   fifo_empty,
  output logic                   rc_en,
  dma_ahb_write_engine_if.master ahb,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] SIZE_WORD    = 3'b010;

  state_e      state_q,     state_d;
  logic [31:0] haddr_q,     haddr_d;
  logic [31:0] hwdata_q,    hwdata_d;
  logic [2:0]  hburst_q,    hburst_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic        first_q,     first_d;
  logic        inc_q,       inc_d;
  logic        pending_q,   pending_d;
  logic        done_q,      done_d;
  logic        error_q,     error_d;

  logic [1:0]  htrans_s;
  logic        accept_s;
  logic        err_resp_s;

  // Address-phase drive: offer a beat only while beats remain and the FIFO
  // head is valid. Since nothing else pops the FIFO, an offered beat stays
  // stable through wait states. The first beat, fixed-address mode and a
  // 1 KB boundary all restart the burst with NONSEQ; a FIFO gap does not.
  always_comb begin
    htrans_s = TRANS_IDLE;
    if ((state_q == ST_XFER) && (issue_cnt_q != 16'd0) && !fifo_empty) begin
      if (first_q || !inc_q || (haddr_q[9:0] == 10'd0)) begin
        htrans_s = TRANS_NONSEQ;
      end else begin
        htrans_s = TRANS_SEQ;
      end
    end else begin
      htrans_s = TRANS_IDLE;
    end
  end

  // A beat is accepted when its address phase completes; the first cycle of
  // a two-cycle ERROR response is recognised only during a data phase.
  assign accept_s   = htrans_s[1] && ahb.HREADY;
  assign err_resp_s = pending_q && ahb.HRESP && !ahb.HREADY;

  // Transfer sequencing: capture the job on start, retire beats and data
  // phases, and raise done/error at the end of a normal or failed transfer.
  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    hburst_d    = hburst_q;
    issue_cnt_d = issue_cnt_q;
    first_d     = first_q;
    inc_d       = inc_q;
    pending_d   = pending_q;
    error_d     = error_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (beat_count != 16'd0) begin
            state_d     = ST_XFER;
            haddr_d     = dst_addr;
            issue_cnt_d = beat_count;
            first_d     = 1'b1;
            inc_d       = dst_inc;
            hburst_d    = dst_inc ? BURST_INCR : BURST_SINGLE;
            pending_d   = 1'b0;
          end else begin
            // Empty job: report completion without touching the bus.
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        if (err_resp_s) begin
          // Abandon the job; the pending address phase is dropped next cycle.
          state_d = ST_ERR;
        end else if (accept_s) begin
          hwdata_d    = fifo_rdata;
          issue_cnt_d = issue_cnt_q - 16'd1;
          first_d     = 1'b0;
          pending_d   = 1'b1;
          if (inc_q) begin
            haddr_d = haddr_q + 32'd4;
          end else begin
            haddr_d = haddr_q;
          end
          if (issue_cnt_q == 16'd1) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_XFER;
          end
        end else if (ahb.HREADY) begin
          pending_d = 1'b0;
        end else begin
          pending_d = pending_q;
        end
      end

      ST_FLUSH: begin
        // Only the last data phase is outstanding here.
        if (err_resp_s) begin
          state_d = ST_ERR;
        end else if (ahb.HREADY) begin
          pending_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end

      ST_ERR: begin
        // Second cycle of the ERROR response completes the failed transfer.
        if (ahb.HREADY) begin
          pending_d = 1'b0;
          error_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      haddr_q     <= 32'd0;
      hwdata_q    <= 32'd0;
      hburst_q    <= BURST_SINGLE;
      issue_cnt_q <= 16'd0;
      first_q     <= 1'b0;
      inc_q       <= 1'b0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      hburst_q    <= hburst_d;
      issue_cnt_q <= issue_cnt_d;
      first_q     <= first_d;
      inc_q       <= inc_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans_s;
  assign ahb.HWRITE = 1'b1;
  assign ahb.HSIZE  = SIZE_WORD;
  assign ahb.HBURST = hburst_q;
  assign ahb.HWDATA = hwdata_q;
  assign rc_en      = accept_s;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_dma_ahb_write_engine.sv
// Self-checking bench for dma_ahb_write_engine: a queue-based FIFO, an AHB
// slave with programmable wait states / ERROR responses, and a beat-level
// reference model (address k = base + 4k, NONSEQ on first beat, fixed mode
// or 1 KB boundary, k-th data word follows k-th pop).
module tb_dma_ahb_write_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] beat_count;
  logic        dst_inc;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        rc_en;
  logic        busy;
  logic        done;
  logic        error;

  dma_ahb_write_engine_if ahb();

  dma_ahb_write_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dst_addr   (dst_addr),
    .beat_count (beat_count),
    .dst_inc    (dst_inc),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .rc_en      (rc_en),
    .ahb        (ahb),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] fq[$];
  logic        err_flag_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
  endtask

  // Runs one transfer end to end against the reference model.
  // wmode: 0 no waits, 1 two waits per data phase, 2 random waits.
  // err_beat: index of the beat whose data phase gets ERROR (-1: none).
  task automatic run_xfer(input logic [31:0] addr, input int n, input bit inc,
                          input int wmode, input int preload, input int gap,
                          input int err_beat, input bit poke, input int exp_done_cyc,
                          input logic [31:0] wbase);
    logic [31:0] words[$];
    logic [31:0] a_exp;
    logic [1:0]  t_exp;
    int acc, dp_idx, pushed, waits, cyc, pops, done_cyc, exp_pops;
    bit dp_active, in_err, done_now, finished, exp_act, hr, hrsp, obs_pop;
    words = {};
    for (int i = 0; i < n; i++) begin
      if (wbase != 32'd0) words.push_back(wbase + 32'(i));
      else                words.push_back($urandom);
    end
    fq = {};
    pushed = 0;
    while ((pushed < preload) && (pushed < n)) begin
      fq.push_back(words[pushed]);
      pushed++;
    end
    fifo_sync();
    acc = 0; dp_idx = 0; waits = 0; pops = 0; done_cyc = -1;
    dp_active = 1'b0; in_err = 1'b0; done_now = 1'b0; finished = 1'b0;

    // Cycle 0: start pulse, engine still idle.
    start = 1'b1; dst_addr = addr; beat_count = 16'(n); dst_inc = inc;
    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
    @(negedge clk);
    chk("c0_htrans", 32'(ahb.HTRANS), 32'd0);
    chk("c0_busy",   32'(busy), 32'd0);
    chk("c0_rc_en",  32'(rc_en), 32'd0);
    chk("c0_error",  32'(error), 32'(err_flag_exp));
    @(posedge clk); #1;
    start = 1'b0;
    err_flag_exp = 1'b0;

    cyc = 1;
    while (!finished && (cyc < 400)) begin
      if ((gap > 0) && (pushed < n) && ((cyc % gap) == 0)) begin
        fq.push_back(words[pushed]);
        pushed++;
      end
      fifo_sync();
      if (poke && (cyc == 2)) begin
        start = 1'b1; dst_addr = addr + 32'h40; beat_count = 16'(n + 3); dst_inc = !inc;
      end else begin
        start = 1'b0;
      end
      hr = 1'b1; hrsp = 1'b0;
      if (dp_active && (err_beat >= 0) && (dp_idx == err_beat)) begin
        hrsp = 1'b1; hr = in_err;
      end else if (dp_active && (wmode == 1)) begin
        hr = (waits >= 2);
      end else if (dp_active && (wmode == 2)) begin
        hr = ($urandom_range(0, 2) != 0);
      end
      ahb.HREADY = hr; ahb.HRESP = hrsp;
      exp_act = !done_now && !in_err && (acc < n) && (fq.size() != 0);

      @(negedge clk);
      obs_pop = rc_en;
      chk("rc_en", 32'(rc_en), 32'(exp_act && hr));
      chk("pop_on_empty", 32'(rc_en && fifo_empty), 32'd0);
      chk("hwrite", 32'(ahb.HWRITE), 32'd1);
      chk("hsize", 32'(ahb.HSIZE), 32'd2);
      if (done_now) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_htrans", 32'(ahb.HTRANS), 32'd0);
        chk("done_error", 32'(error), 32'(err_flag_exp));
        done_cyc = cyc;
      end else begin
        chk("htrans_act", 32'(ahb.HTRANS != 2'b00), 32'(exp_act));
        chk("busy", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("error_mid", 32'(error), 32'd0);
        if (exp_act) begin
          a_exp = inc ? (addr + (32'(acc) << 2)) : addr;
          t_exp = ((acc == 0) || !inc || (a_exp[9:0] == 10'd0)) ? 2'b10 : 2'b11;
          chk("haddr", ahb.HADDR, a_exp);
          chk("htrans", 32'(ahb.HTRANS), 32'(t_exp));
          chk("hburst", 32'(ahb.HBURST), 32'(inc));
        end
        if (dp_active) chk("hwdata", ahb.HWDATA, words[dp_idx]);
      end

      @(posedge clk); #1;
      if (obs_pop && (fq.size() != 0)) begin
        void'(fq.pop_front());
        pops++;
      end
      if (done_now) begin
        finished = 1'b1;
      end else if (dp_active && (err_beat >= 0) && (dp_idx == err_beat)) begin
        if (in_err) begin
          dp_active = 1'b0; err_flag_exp = 1'b1; done_now = 1'b1;
        end else begin
          in_err = 1'b1;
        end
      end else begin
        if (dp_active && hr) begin
          dp_active = 1'b0; waits = 0;
          if (dp_idx == n - 1) done_now = 1'b1;
        end else if (dp_active) begin
          waits++;
        end
        if (exp_act && hr) begin
          dp_active = 1'b1; dp_idx = acc; acc++;
        end
      end
      cyc++;
    end
    chk("finished", 32'(finished), 32'd1);

    // Cycle after done: pulse over, bus idle.
    start = 1'b0; ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
    fifo_sync();
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_htrans", 32'(ahb.HTRANS), 32'd0);
    chk("post_rc_en", 32'(rc_en), 32'd0);
    chk("post_error", 32'(error), 32'(err_flag_exp));
    @(posedge clk); #1;
    exp_pops = (err_beat >= 0) ? (err_beat + 1) : n;
    chk("pops", 32'(pops), 32'(exp_pops));
    chk("fifo_left", 32'(fq.size()), 32'(pushed - exp_pops));
    if (exp_done_cyc >= 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
  endtask

  initial begin
    logic pop_obs;
    rst = 1'b0; start = 1'b0; dst_addr = 32'd0; beat_count = 16'd0; dst_inc = 1'b0;
    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
    fq = {};
    fifo_sync();

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_htrans", 32'(ahb.HTRANS), 32'd0);
    chk("rst_haddr", ahb.HADDR, 32'd0);
    chk("rst_hwdata", ahb.HWDATA, 32'd0);
    chk("rst_hburst", 32'(ahb.HBURST), 32'd0);
    chk("rst_rc_en", 32'(rc_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hwrite", 32'(ahb.HWRITE), 32'd1);
    chk("rst_hsize", 32'(ahb.HSIZE), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // INCR burst, zero waits, full FIFO: done in cycle N+2 = 6.
    run_xfer(32'h0000_0100, 4, 1'b1, 0, 4, 0, -1, 1'b0, 6, 32'h0000_0010);
    // Fixed address with two wait states per data phase.
    run_xfer(32'h0000_2000, 3, 1'b0, 1, 3, 0, -1, 1'b0, -1, 32'd0);
    // FIFO starvation: one word up front, the rest every 5 cycles.
    run_xfer(32'h0000_0500, 3, 1'b1, 0, 1, 5, -1, 1'b0, -1, 32'd0);
    // 1 KB boundary crossing.
    run_xfer(32'h0000_03F8, 4, 1'b1, 0, 4, 0, -1, 1'b0, -1, 32'd0);
    // Address wrap at 2^32 (also a 1 KB boundary).
    run_xfer(32'hFFFF_FFF8, 4, 1'b1, 0, 4, 0, -1, 1'b0, -1, 32'd0);
    // ERROR on the third beat of five: three pops, two words left.
    run_xfer(32'h0000_3000, 5, 1'b1, 0, 5, 0, 2, 1'b0, -1, 32'd0);
    // Next accepted start clears the sticky error; start while busy ignored.
    run_xfer(32'h0000_4000, 6, 1'b1, 2, 6, 0, -1, 1'b1, -1, 32'd0);

    // beat_count = 0: done pulse, no pop, no bus activity.
    fq = {};
    fq.push_back(32'hCAFE_0001);
    fifo_sync();
    start = 1'b1; dst_addr = 32'h0000_5000; beat_count = 16'd0; dst_inc = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_htrans", 32'(ahb.HTRANS), 32'd0);
    chk("zero_rc_en", 32'(rc_en), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_once", 32'(done), 32'd0);
    chk("zero_rc_en2", 32'(rc_en), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a burst.
    fq = {};
    for (int i = 0; i < 8; i++) fq.push_back($urandom);
    fifo_sync();
    start = 1'b1; dst_addr = 32'h0000_6000; beat_count = 16'd8; dst_inc = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pop_obs = rc_en;
      @(posedge clk); #1;
      if (pop_obs && (fq.size() != 0)) void'(fq.pop_front());
      fifo_sync();
    end
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    pop_obs = rc_en;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    if (pop_obs && (fq.size() != 0)) void'(fq.pop_front());
    fifo_sync();
    @(negedge clk);
    chk("mrst_htrans", 32'(ahb.HTRANS), 32'd0);
    chk("mrst_haddr", ahb.HADDR, 32'd0);
    chk("mrst_hwdata", ahb.HWDATA, 32'd0);
    chk("mrst_hburst", 32'(ahb.HBURST), 32'd0);
    chk("mrst_rc_en", 32'(rc_en), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    err_flag_exp = 1'b0;

    // Randomised jobs against the same model.
    for (int k = 0; k < 12; k++) begin
      logic [31:0] ra;
      int rn, rp, rg, re, rw;
      bit ri;
      ra = $urandom & 32'hFFFF_FFFC;
      if ((k % 3) == 0) ra = (ra & 32'hFFFF_FC00) | 32'h0000_03F0;
      rn = int'($urandom_range(1, 9));
      ri = 1'($urandom_range(0, 1));
      rw = int'($urandom_range(0, 2));
      rp = int'($urandom_range(0, rn));
      rg = (rp < rn) ? int'($urandom_range(1, 4)) : 0;
      re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn - 1)) : -1;
      run_xfer(ra, rn, ri, rw, rp, rg, re, 1'b0, -1, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
